// File: rtl/beta_bus_arbiter.sv
// rtl/beta_bus_arbiter.sv - round-robin arbiter sharing the beta memory port between camera writes and projector reads
// Optional BETA_ARB_BURST_EN keeps a grant for up to MAX_BURST back-to-back transfers.
module beta_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cam_req,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_din,
    output logic          cam_rdy,
    input  logic          proj_req,
    input  logic [AW-1:0] proj_addr,
    output logic          proj_rdy,
    output logic [DW-1:0] proj_dout,
    output logic          proj_valid,
    output logic [AW-1:0] beta_addr,
    output logic [DW-1:0] beta_din,
    output logic          beta_we,
    input  logic [DW-1:0] beta_dout
);

`ifdef BETA_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    // Without bursts a grant is simply a burst of length one.
    localparam int             BURST_LIM   = BURST_EN ? MAX_BURST : 1;
    localparam int             BW          = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_LIM_W = BW'(BURST_LIM);
    localparam logic [3:0]     LAT_INIT    = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAM,
        S_PROJ,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            last_cam_q, last_cam_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [BW-1:0]   burst_nxt;
    logic [AW-1:0]   beta_addr_q, beta_addr_d;
    logic [DW-1:0]   beta_din_q, beta_din_d;
    logic            beta_we_q, beta_we_d;
    logic [DW-1:0]   proj_dout_q, proj_dout_d;

    assign burst_nxt = burst_cnt_q + BW'(1);

    always_comb begin
        state_d     = state_q;
        last_cam_d  = last_cam_q;
        lat_cnt_d   = lat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        beta_addr_d = beta_addr_q;
        beta_din_d  = beta_din_q;
        beta_we_d   = 1'b0;
        proj_dout_d = proj_dout_q;
        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time is served.
                if (cam_req && (!proj_req || !last_cam_q)) begin
                    state_d     = S_CAM;
                    last_cam_d  = 1'b1;
                    burst_cnt_d = '0;
                end else if (proj_req) begin
                    state_d     = S_PROJ;
                    last_cam_d  = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            S_CAM: begin
                if (cam_req) begin
                    beta_addr_d = cam_addr;
                    beta_din_d  = cam_din;
                    beta_we_d   = 1'b1;
                    burst_cnt_d = burst_nxt;
                    state_d     = (burst_nxt < BURST_LIM_W) ? S_CAM : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PROJ: begin
                if (proj_req) begin
                    beta_addr_d = proj_addr;
                    lat_cnt_d   = LAT_INIT;
                    burst_cnt_d = burst_nxt;
                    state_d     = S_RD_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    proj_dout_d = beta_dout;
                    state_d     = S_RD_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_RD_DONE: begin
                state_d = (proj_req && (burst_cnt_q < BURST_LIM_W)) ? S_PROJ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            last_cam_q  <= 1'b0;
            lat_cnt_q   <= '0;
            burst_cnt_q <= '0;
            beta_addr_q <= '0;
            beta_din_q  <= '0;
            beta_we_q   <= 1'b0;
            proj_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            last_cam_q  <= last_cam_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            beta_addr_q <= beta_addr_d;
            beta_din_q  <= beta_din_d;
            beta_we_q   <= beta_we_d;
            proj_dout_q <= proj_dout_d;
        end
    end

    assign cam_rdy    = (state_q == S_CAM);
    assign proj_rdy   = (state_q == S_PROJ);
    assign proj_valid = (state_q == S_RD_DONE);
    assign beta_addr  = beta_addr_q;
    assign beta_din   = beta_din_q;
    assign beta_we    = beta_we_q;
    assign proj_dout  = proj_dout_q;

endmodule

// File: tb/tb_beta_bus_arbiter.sv
// tb/tb_beta_bus_arbiter.sv - self-checking bench for beta_bus_arbiter
module tb_beta_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RD_LAT = 2;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cam_req = 1'b0;
    logic [AW-1:0] cam_addr = '0;
    logic [DW-1:0] cam_din = '0;
    logic          cam_rdy;
    logic          proj_req = 1'b0;
    logic [AW-1:0] proj_addr = '0;
    logic          proj_rdy;
    logic [DW-1:0] proj_dout;
    logic          proj_valid;
    logic [AW-1:0] beta_addr;
    logic [DW-1:0] beta_din;
    logic          beta_we;
    logic [DW-1:0] beta_dout;
    logic [DW-1:0] mem_q = '0;

    int tests = 0;
    int errors = 0;

    beta_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .cam_req(cam_req), .cam_addr(cam_addr), .cam_din(cam_din), .cam_rdy(cam_rdy),
        .proj_req(proj_req), .proj_addr(proj_addr), .proj_rdy(proj_rdy),
        .proj_dout(proj_dout), .proj_valid(proj_valid),
        .beta_addr(beta_addr), .beta_din(beta_din), .beta_we(beta_we), .beta_dout(beta_dout)
    );

    always #5 clk = ~clk;

    // Memory returns addr^0xFFFF, settled well before the arbiter samples it.
    always @(posedge clk) mem_q <= beta_addr ^ 32'h0000FFFF;
    assign beta_dout = mem_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: transfers observed on the handshake predict the beta write and read return.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rd_t;
    rd_t           rdq[$];
    int            cyc = 0;
    bit            prev_ok = 0;
    bit            exp_we = 0;
    logic [AW-1:0] exp_wa = '0;
    logic [DW-1:0] exp_wd = '0;
    bit            prev_cam_req = 0;
    bit            prev_proj_req = 0;

    always @(negedge clk) begin
        bit ev;
        if (!reset_n) begin
            rdq.delete();
            prev_ok = 0;
            exp_we  = 0;
        end else begin
            if (prev_ok) begin
                chk("m_we", beta_we, exp_we);
                if (exp_we) begin
                    chk("m_waddr", beta_addr, exp_wa);
                    chk("m_wdata", beta_din, exp_wd);
                end
                ev = (rdq.size() > 0) && (rdq[0].due == cyc);
                chk("m_valid", proj_valid, ev);
                if (ev) begin
                    chk("m_rdata", proj_dout, rdq[0].addr ^ 32'h0000FFFF);
                    void'(rdq.pop_front());
                end
                chk("m_excl", cam_rdy & proj_rdy, 0);
                chk("m_cam_blocked", cam_rdy && (rdq.size() != 0), 0);
                chk("m_cam_unreq", cam_rdy && !prev_cam_req, 0);
                chk("m_proj_unreq", proj_rdy && !prev_proj_req, 0);
            end
            exp_we = cam_req & cam_rdy;
            exp_wa = cam_addr;
            exp_wd = cam_din;
            if (proj_req & proj_rdy) rdq.push_back('{proj_addr, cyc + RD_LAT + 1});
            prev_cam_req  = cam_req;
            prev_proj_req = proj_req;
            prev_ok       = 1;
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wecount;
        int ng;
        int xfers;
        int len;
        bit started;
        bit prev_busy;
        logic [3:0]  order;
        logic [15:0] pat;
        logic [15:0] exp_pat;
        int          exp_len;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {cam_rdy, proj_rdy, proj_valid, beta_we}, 0);
        chk("rst_addr", beta_addr, 0);
        chk("rst_din", beta_din, 0);
        chk("rst_dout", proj_dout, 0);

        // First camera write
        @(posedge clk); #1;
        reset_n = 1; cam_req = 1; cam_addr = 32'h10; cam_din = 32'hAB;
        @(posedge clk); @(negedge clk);
        chk("wr_cam_rdy", cam_rdy, 1);
        chk("wr_no_we_yet", beta_we, 0);
        @(posedge clk); #1;
        cam_req = 0;
        @(negedge clk);
        chk("wr_we", beta_we, 1);
        chk("wr_addr", beta_addr, 32'h10);
        chk("wr_din", beta_din, 32'hAB);
        chk("wr_rdy_gone", cam_rdy, 0);
        @(negedge clk);
        chk("wr_we_one_cycle", beta_we, 0);

        // Single read
        @(posedge clk); #1;
        proj_req = 1; proj_addr = 32'h40;
        n = 0;
        @(negedge clk);
        while (!proj_rdy && n < 10) begin @(negedge clk); n++; end
        chk("rd_grant_delay", n, 1);
        @(posedge clk); #1;
        proj_req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!proj_valid && n < 10);
        chk("rd_latency", n, 3);
        chk("rd_data", proj_dout, 32'hFFBF);
        @(negedge clk);
        chk("rd_valid_pulse", proj_valid, 0);

        // Camera grant lapses, projector served next
        @(posedge clk); #1;
        cam_req = 1; cam_addr = 32'h200; cam_din = 32'h77;
        @(posedge clk); #1;
        chk("lapse_cam_rdy", cam_rdy, 1);
        cam_req = 0; proj_req = 1; proj_addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        chk("lapse_idle", {cam_rdy, proj_rdy, beta_we}, 0);
        n = 0; wecount = 0;
        while (!proj_rdy && n < 10) begin
            @(negedge clk); n++;
            if (beta_we) wecount++;
        end
        chk("lapse_proj_grant", n, 1);
        @(posedge clk); #1;
        proj_req = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (beta_we) wecount++;
        end while (!proj_valid && n < 10);
        chk("lapse_rd_data", proj_dout, 32'hFF7F);
        chk("lapse_no_write", wecount, 0);

        // Reset during RD_WAIT
        @(posedge clk); #1;
        proj_req = 1; proj_addr = 32'h20;
        n = 0;
        do begin @(negedge clk); n++; end while (!proj_rdy && n < 10);
        chk("rr_grant", proj_rdy, 1);
        @(posedge clk); #1;
        proj_req = 0;
        reset_n = 0;
        #1;
        chk("rr_async_flags", {cam_rdy, proj_rdy, proj_valid, beta_we}, 0);
        chk("rr_async_addr", beta_addr, 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (proj_valid) n++;
        end
        chk("rr_no_valid", n, 0);
        chk("rr_dout", proj_dout, 0);

        // Tie from reset: round-robin order
        @(posedge clk); #1;
        reset_n = 1;
        cam_req = 1; cam_addr = 32'h300; cam_din = 32'h33;
        proj_req = 1; proj_addr = 32'h44;
        order = '0; ng = 0; prev_busy = 0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            @(negedge clk);
            if ((cam_rdy || proj_rdy) && !prev_busy) begin
                order = {order[2:0], cam_rdy};
                ng++;
            end
            prev_busy = cam_rdy || proj_rdy || proj_valid;
        end
        @(posedge clk); #1;
        cam_req = 0; proj_req = 0;
        chk("tie_grants", ng, 4);
        chk("tie_order", order, 4'b1010);
        repeat (10) @(negedge clk);

        // Six back-to-back camera writes
`ifdef BETA_ARB_BURST_EN
        exp_pat = 16'b0000000001111011; exp_len = 7;
`else
        exp_pat = 16'b0000010101010101; exp_len = 11;
`endif
        @(posedge clk); #1;
        cam_req = 1; cam_addr = 32'h100; cam_din = 32'h5000;
        xfers = 0; len = 0; pat = '0; started = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (beta_we) begin
                xfers++;
                cam_addr = cam_addr + 32'd4;
                cam_din  = cam_din + 32'd1;
                if (xfers == 6) cam_req = 0;
            end
            @(negedge clk);
            if (beta_we) started = 1;
            if (started && len < 16) begin
                pat = {pat[14:0], beta_we};
                len++;
            end
            if (xfers == 6) break;
        end
        chk("burst_count", xfers, 6);
        chk("burst_len", len, exp_len);
        chk("burst_pattern", pat, exp_pat);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
